// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory; one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: fixed priority, r0 wins).
module dmem_arbiter #(
  parameter int AW  = 10,
  parameter int LAT = 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [31:0]   r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [31:0]   r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [31:0]   r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [31:0]   r1_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       owner_r;
  logic       last_r;
  logic       winner_s;

  // Winner selection; with no request pending the value is irrelevant.
  always_comb begin
    winner_s = last_r;
`ifdef ARB_ROUND_ROBIN_EN
    if (r0_req && r1_req) begin
      winner_s = ~last_r;
    end else if (r0_req) begin
      winner_s = 1'b0;
    end else if (r1_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = last_r;
    end
`else
    if (r0_req) begin
      winner_s = 1'b0;
    end else if (r1_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = last_r;
    end
`endif
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      r0_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r0_rdata  <= 32'd0;
      r1_gnt    <= 1'b0;
      r1_rvalid <= 1'b0;
      r1_rdata  <= 32'd0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= 32'd0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      m_en      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner_r <= winner_s;
            m_en    <= 1'b1;
            m_we    <= winner_s ? r1_we    : r0_we;
            m_addr  <= winner_s ? r1_addr  : r0_addr;
            m_wdata <= winner_s ? r1_wdata : r0_wdata;
            r0_gnt  <= ~winner_s;
            r1_gnt  <= winner_s;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // m_we still holds this transaction's direction until this edge.
          last_r <= owner_r;
          m_we   <= 1'b0;
          if (m_we) begin
            state_r <= IDLE;
          end else begin
            cnt_r   <= 4'(LAT - 1);
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (owner_r) begin
              r1_rdata  <= m_rdata;
              r1_rvalid <= 1'b1;
            end else begin
              r0_rdata  <= m_rdata;
              r0_rvalid <= 1'b1;
            end
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one LAT=1 instance with a small memory model,
// one LAT=3 instance with a pipelined read model for latency and reset checks.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  always #5 clock = ~clock;

  // LAT=1 instance
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [9:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  // LAT=3 instance
  logic        l3_r0_req, l3_r0_we, l3_r1_req, l3_r1_we;
  logic [9:0]  l3_r0_addr, l3_r1_addr;
  logic [31:0] l3_r0_wdata, l3_r1_wdata;
  logic        l3_r0_gnt, l3_r0_rvalid, l3_r1_gnt, l3_r1_rvalid;
  logic [31:0] l3_r0_rdata, l3_r1_rdata;
  logic        l3_m_en, l3_m_we;
  logic [9:0]  l3_m_addr;
  logic [31:0] l3_m_wdata, l3_m_rdata;
  logic [31:0] p0, p1, p2;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.AW(10), .LAT(1)) u_dut (
    .clock(clock), .resetn(resetn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  dmem_arbiter #(.AW(10), .LAT(3)) u_dut_l3 (
    .clock(clock), .resetn(resetn),
    .r0_req(l3_r0_req), .r0_we(l3_r0_we), .r0_addr(l3_r0_addr), .r0_wdata(l3_r0_wdata),
    .r0_gnt(l3_r0_gnt), .r0_rvalid(l3_r0_rvalid), .r0_rdata(l3_r0_rdata),
    .r1_req(l3_r1_req), .r1_we(l3_r1_we), .r1_addr(l3_r1_addr), .r1_wdata(l3_r1_wdata),
    .r1_gnt(l3_r1_gnt), .r1_rvalid(l3_r1_rvalid), .r1_rdata(l3_r1_rdata),
    .m_en(l3_m_en), .m_we(l3_m_we), .m_addr(l3_m_addr), .m_wdata(l3_m_wdata),
    .m_rdata(l3_m_rdata)
  );

  // Single-port memory, read latency 1; preloaded while reset is held.
  logic [31:0] mem [0:15];
  always @(posedge clock) begin
    if (!resetn) begin
      mem[1] <= 32'h11111111;
      mem[2] <= 32'h22222222;
      mem[5] <= 32'hDEADBEEF;
    end else begin
      if (m_en && m_we) mem[m_addr[3:0]] <= m_wdata;
      if (m_en && !m_we) m_rdata <= mem[m_addr[3:0]];
    end
  end

  // Three-stage read pipeline; data is a tag of the address, zero when no read was issued.
  always @(posedge clock) begin
    p0 <= (l3_m_en && !l3_m_we) ? (32'hA5A50000 | {22'd0, l3_m_addr}) : 32'd0;
    p1 <= p0;
    p2 <= p1;
  end
  assign l3_m_rdata = p2;

  // Protocol monitor on the LAT=1 instance.
  int   en_cnt = 0, gnt_cnt = 0, b2b_cnt = 0, align_err = 0;
  logic prev_en = 1'b0;
  always @(negedge clock) begin
    if (resetn) begin
      if (m_en) en_cnt <= en_cnt + 1;
      if (r0_gnt || r1_gnt) gnt_cnt <= gnt_cnt + 1;
      if (m_en && prev_en) b2b_cnt <= b2b_cnt + 1;
      if ((r0_gnt || r1_gnt) != m_en) align_err <= align_err + 1;
      if (r0_gnt && r1_gnt) align_err <= align_err + 1;
      prev_en <= m_en;
    end else begin
      prev_en <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int seq[4];
    int ng, guard;
    logic found;
    resetn = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 10'd0; r0_wdata = 32'd0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 10'd0; r1_wdata = 32'd0;
    l3_r0_req = 1'b0; l3_r0_we = 1'b0; l3_r0_addr = 10'd0; l3_r0_wdata = 32'd0;
    l3_r1_req = 1'b0; l3_r1_we = 1'b0; l3_r1_addr = 10'd0; l3_r1_wdata = 32'd0;
    tick(); tick();
    check_eq("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    check_eq("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
    check_eq("rst_r0_rdata", r0_rdata, 32'd0);
    check_eq("rst_m_en", {31'd0, m_en}, 32'd0);
    check_eq("rst_m_addr", {22'd0, m_addr}, 32'd0);
    resetn = 1'b1;
    tick();

    // T1: r0 read addr 5
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd5;
    tick();
    check_eq("t1_gnt", {31'd0, r0_gnt}, 32'd1);
    check_eq("t1_m_en", {31'd0, m_en}, 32'd1);
    check_eq("t1_m_addr", {22'd0, m_addr}, 32'd5);
    r0_req = 1'b0;
    tick();
    check_eq("t1_gnt_off", {31'd0, r0_gnt}, 32'd0);
    check_eq("t1_rvalid_early", {31'd0, r0_rvalid}, 32'd0);
    tick();
    check_eq("t1_rvalid", {31'd0, r0_rvalid}, 32'd1);
    check_eq("t1_rdata", r0_rdata, 32'hDEADBEEF);
    check_eq("t1_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
    tick();
    check_eq("t1_rvalid_off", {31'd0, r0_rvalid}, 32'd0);
    check_eq("t1_rdata_held", r0_rdata, 32'hDEADBEEF);

    // T2: r1 write then read addr 3
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd3; r1_wdata = 32'h12345678;
    tick();
    check_eq("t2_gnt", {31'd0, r1_gnt}, 32'd1);
    check_eq("t2_m_we", {31'd0, m_we}, 32'd1);
    check_eq("t2_m_addr", {22'd0, m_addr}, 32'd3);
    check_eq("t2_m_wdata", m_wdata, 32'h12345678);
    r1_req = 1'b0;
    tick();
    check_eq("t2_m_we_off", {31'd0, m_we}, 32'd0);
    check_eq("t2_m_en_off", {31'd0, m_en}, 32'd0);
    r1_req = 1'b1; r1_we = 1'b0;
    tick();
    check_eq("t2_rd_gnt", {31'd0, r1_gnt}, 32'd1);
    r1_req = 1'b0;
    tick(); tick();
    check_eq("t2_rvalid", {31'd0, r1_rvalid}, 32'd1);
    check_eq("t2_rdata", r1_rdata, 32'h12345678);
    check_eq("t2_r0_rdata_kept", r0_rdata, 32'hDEADBEEF);
    tick();

    // T3: simultaneous reads, both requests held
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd1;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd2;
    ng = 0; guard = 0;
    while (ng < 4 && guard < 60) begin
      tick();
      guard++;
      if (r0_gnt) begin seq[ng] = 0; ng++; end
      else if (r1_gnt) begin seq[ng] = 1; ng++; end
    end
    check_eq("t3_ngrants", ng, 4);
`ifdef ARB_ROUND_ROBIN_EN
    r0_req = 1'b0; r1_req = 1'b0;
    check_eq("t3_rr0", seq[0], 0);
    check_eq("t3_rr1", seq[1], 1);
    check_eq("t3_rr2", seq[2], 0);
    check_eq("t3_rr3", seq[3], 1);
`else
    r0_req = 1'b0;
    for (int i = 0; i < 4; i++) check_eq("t3_fixed", seq[i], 0);
    found = 1'b0; guard = 0;
    while (!found && guard < 20) begin
      tick();
      guard++;
      if (r1_gnt) found = 1'b1;
    end
    r1_req = 1'b0;
    check_eq("t3_r1_late_gnt", {31'd0, found}, 32'd1);
    tick(); tick();
    check_eq("t3_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
    check_eq("t3_r1_rdata", r1_rdata, 32'h22222222);
`endif
    tick(); tick(); tick(); tick();
    check_eq("t3_r0_rdata", r0_rdata, 32'h11111111);

    // T4: LAT=3, m_en to rvalid is 4 cycles
    l3_r0_req = 1'b1; l3_r0_addr = 10'd7;
    tick();
    check_eq("t4_m_en", {31'd0, l3_m_en}, 32'd1);
    l3_r0_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("t4_rvalid", {31'd0, l3_r0_rvalid}, (i == 4) ? 32'd1 : 32'd0);
      check_eq("t4_r1_rvalid", {31'd0, l3_r1_rvalid}, 32'd0);
      check_eq("t4_r1_rdata", l3_r1_rdata, 32'd0);
    end
    check_eq("t4_rdata", l3_r0_rdata, 32'hA5A50007);
    tick();

    // T5: reset while in WAIT
    l3_r0_req = 1'b1; l3_r0_addr = 10'd9;
    tick();
    l3_r0_req = 1'b0;
    tick(); tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_eq("t5_rdata_cleared", l3_r0_rdata, 32'd0);
    check_eq("t5_m_en", {31'd0, l3_m_en}, 32'd0);
    check_eq("t5_gnt", {31'd0, l3_r0_gnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t5_no_rvalid", {31'd0, l3_r0_rvalid}, 32'd0);
    end
    l3_r0_req = 1'b1; l3_r0_addr = 10'd4;
    tick();
    check_eq("t5_fresh_gnt", {31'd0, l3_r0_gnt}, 32'd1);
    l3_r0_req = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("t5_fresh_rvalid", {31'd0, l3_r0_rvalid}, 32'd1);
    check_eq("t5_fresh_rdata", l3_r0_rdata, 32'hA5A50004);

    // T6: held write request is re-issued only after one idle cycle
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd6; r0_wdata = 32'h00000066;
    tick();
    check_eq("t6_gnt1", {31'd0, r0_gnt}, 32'd1);
    tick();
    check_eq("t6_gap", {31'd0, r0_gnt | m_en}, 32'd0);
    tick();
    check_eq("t6_gnt2", {31'd0, r0_gnt}, 32'd1);
    r0_req = 1'b0;
    tick(); tick();
    check_eq("t6_pulses", en_cnt, gnt_cnt);
    check_eq("t6_back2back", b2b_cnt, 0);
    check_eq("t6_align", align_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
